// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle ops retire one cycle after accept, signed MUL/DIV
// iterate one bit per cycle through a shared shift/add-subtract engine.
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       AluOP,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_2,
    output logic             Equal,
    output logic             Less,
    output logic             NotLess,
    output logic             DivZero,
    output logic [1:0]       fsm_state
);

    // Handshake: a request is taken on a rising edge where start=1, busy=0 and
    // the FSM is IDLE; AluOP/X/Y are sampled on that edge only. done pulses for
    // one cycle when results are valid; starts while busy or in DONE are dropped.

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic             sx;
    logic             sy;
    logic             is_div;
    logic             y_zero;

    logic             accept;
    logic             iter_op;
    logic [SHW-1:0]   sh;
    logic             slt;
    logic             sltu;
    logic             less_nxt;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;

    assign busy      = (state == RUN) || (state == FIX);
    assign done      = (state == DONE);
    assign fsm_state = state;

    assign accept  = start && !busy && (state == IDLE);
    assign iter_op = (AluOP == OP_MUL) || (AluOP == OP_DIV);
    assign sh      = Y[SHW-1:0];
    assign slt     = $signed(X) < $signed(Y);
    assign sltu    = X < Y;
    assign x_mag   = X[WIDTH-1] ? -X : X;
    assign y_mag   = Y[WIDTH-1] ? -Y : Y;

    always_comb begin
        less_nxt = 1'b0;
        if (AluOP == OP_SLT) begin
            less_nxt = slt;
        end else if (AluOP == OP_SLTU) begin
            less_nxt = sltu;
        end
    end

    always_comb begin
        single_res = '0;
        case (AluOP)
            OP_SLL:  single_res = X << sh;
            OP_SRA:  single_res = $signed(X) >>> sh;
            OP_SRL:  single_res = X >> sh;
            OP_ADD:  single_res = X + Y;
            OP_SUB:  single_res = X - Y;
            OP_AND:  single_res = X & Y;
            OP_OR:   single_res = X | Y;
            OP_XOR:  single_res = X ^ Y;
            OP_NOR:  single_res = ~(X | Y);
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, sltu};
            default: single_res = '0;
        endcase
    end

    // MUL keeps {acc,lo} as a right-shifting product with the multiplier in lo;
    // DIV keeps the partial remainder in acc and shifts quotient bits into lo.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] lo_nxt;

    assign add_sum = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign shifted = {acc, lo[WIDTH-1]};
    assign diff    = shifted - {1'b0, mcand};

    always_comb begin
        acc_nxt = acc;
        lo_nxt  = lo;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_nxt = diff[WIDTH-1:0];
                lo_nxt  = {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[WIDTH-1:0];
                lo_nxt  = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            {acc_nxt, lo_nxt} = {add_sum, lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = (sx ^ sy) ? -{acc, lo} : {acc, lo};
    assign quo_fix  = (sx ^ sy) ? -lo : lo;
    assign rem_fix  = sx ? -acc : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = iter_op ? RUN : DONE;
            RUN:     if (cnt == LAST_STEP) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Result   <= '0;
            Result_2 <= '0;
            Equal    <= 1'b0;
            Less     <= 1'b0;
            NotLess  <= 1'b1;
            DivZero  <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            lo       <= '0;
            mcand    <= '0;
            sx       <= 1'b0;
            sy       <= 1'b0;
            is_div   <= 1'b0;
            y_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        Equal   <= (X == Y);
                        Less    <= less_nxt;
                        NotLess <= ~less_nxt;
                        DivZero <= 1'b0;
                        if (iter_op) begin
                            cnt    <= '0;
                            acc    <= '0;
                            sx     <= X[WIDTH-1];
                            sy     <= Y[WIDTH-1];
                            is_div <= (AluOP == OP_DIV);
                            y_zero <= (Y == '0);
                            if (AluOP == OP_DIV) begin
                                lo    <= x_mag;
                                mcand <= y_mag;
                            end else begin
                                lo    <= y_mag;
                                mcand <= x_mag;
                            end
                        end else begin
                            Result   <= single_res;
                            Result_2 <= '0;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + SHW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        // A zero divisor leaves |X| in the remainder, so the
                        // signed fix-up already yields Result_2 = X.
                        Result   <= y_zero ? '1 : quo_fix;
                        Result_2 <= rem_fix;
                        DivZero  <= y_zero;
                    end else begin
                        {Result_2, Result} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit and an 8-bit instance driven through a vector
// table plus hand-written multi-cycle sequences, checked through an expected queue.
module tb_alu_seq;

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;
    localparam int EW = 68;
    localparam int NV = 14;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic        eq;
        logic        less;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sel;

    logic        start32, busy32, done32, eq32, less32, nl32, dz32;
    logic [3:0]  op32;
    logic [31:0] x32, y32, res32, res2_32;
    logic [1:0]  st32;

    logic        start8, busy8, done8, eq8, less8, nl8, dz8;
    logic [3:0]  op8;
    logic [7:0]  x8, y8, res8, res2_8;
    logic [1:0]  st8;

    logic        m_busy, m_done, m_eq, m_less, m_nl, m_dz;
    logic [31:0] m_res, m_res2;

    int tests_run = 0;
    int tests_failed = 0;
    logic [EW-1:0] exp_q[$];
    vec_t vecs [NV];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .AluOP(op32), .X(x32), .Y(y32),
        .busy(busy32), .done(done32), .Result(res32), .Result_2(res2_32),
        .Equal(eq32), .Less(less32), .NotLess(nl32), .DivZero(dz32), .fsm_state(st32)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .AluOP(op8), .X(x8), .Y(y8),
        .busy(busy8), .done(done8), .Result(res8), .Result_2(res2_8),
        .Equal(eq8), .Less(less8), .NotLess(nl8), .DivZero(dz8), .fsm_state(st8)
    );

    assign m_busy = sel ? busy8 : busy32;
    assign m_done = sel ? done8 : done32;
    assign m_eq   = sel ? eq8   : eq32;
    assign m_less = sel ? less8 : less32;
    assign m_nl   = sel ? nl8   : nl32;
    assign m_dz   = sel ? dz8   : dz32;
    assign m_res  = sel ? {24'h0, res8}   : res32;
    assign m_res2 = sel ? {24'h0, res2_8} : res2_32;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_pins(input logic st, input logic [3:0] op, input logic [31:0] x,
                              input logic [31:0] y);
        if (sel) begin
            start8 = st; op8 = op; x8 = x[7:0]; y8 = y[7:0];
        end else begin
            start32 = st; op32 = op; x32 = x; y32 = y;
        end
    endtask

    // Returns just after the accept edge (cycle 0).
    task automatic drive_start(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        drive_pins(1'b1, op, x, y);
        @(posedge clk);
        #1;
        drive_pins(1'b0, op, x, y);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [31:0] er2,
                         input logic eeq, input logic eless, input logic edz);
        exp_q.push_back({er, er2, eeq, eless, ~eless, edz});
        drive_start(op, x, y);
    endtask

    task automatic wait_done(input int exp_lat, input int inject_cyc, input string tag);
        int lat;
        int busy_n;
        logic [EW-1:0] e;
        lat = 0;
        busy_n = 0;
        for (int c = 1; c <= 80 && lat == 0; c++) begin
            @(negedge clk);
            if (c == inject_cyc) drive_pins(1'b1, OP_ADD, 32'h1, 32'h1);
            else if (c == inject_cyc + 1) drive_pins(1'b0, OP_ADD, 32'h1, 32'h1);
            if (m_busy) busy_n++;
            if (m_done) lat = c;
        end
        if (inject_cyc > 0) drive_pins(1'b0, OP_ADD, 32'h1, 32'h1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 64'(0), 64'(1));
        end else begin
            e = exp_q.pop_front();
            if (lat != 0) begin
                check({tag, "_res"},     64'(m_res),  64'(e[67:36]));
                check({tag, "_res2"},    64'(m_res2), 64'(e[35:4]));
                check({tag, "_equal"},   64'(m_eq),   64'(e[3]));
                check({tag, "_less"},    64'(m_less), 64'(e[2]));
                check({tag, "_notless"}, 64'(m_nl),   64'(e[1]));
                check({tag, "_divzero"}, 64'(m_dz),   64'(e[0]));
                @(negedge clk);
                check({tag, "_done_pulse"}, 64'(m_done), 64'(0));
                check({tag, "_hold"},       64'(m_res),  64'(e[67:36]));
            end
        end
    endtask

    initial begin
        logic [31:0] rx, ry, er, er2;
        logic [3:0]  rop;
        int xs, ys, q, r;
        longint p;
        bit seen_done;

        sel = 1'b0;
        rst = 1'b1;
        start32 = 1'b0; op32 = '0; x32 = '0; y32 = '0;
        start8  = 1'b0; op8  = '0; x8  = '0; y8  = '0;

        vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0};
        vecs[1]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1};
        vecs[2]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3]  = '{OP_SLL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0};
        vecs[4]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0};
        vecs[5]  = '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0};
        vecs[6]  = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
        vecs[8]  = '{OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0};
        vecs[9]  = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0};
        vecs[10] = '{OP_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0};
        vecs[11] = '{4'd13,   32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
        vecs[12] = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
        vecs[13] = '{OP_SLT,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",    64'(busy32),  64'(0));
        check("rst_done",    64'(done32),  64'(0));
        check("rst_res",     64'(res32),   64'(0));
        check("rst_res2",    64'(res2_32), 64'(0));
        check("rst_eq_less", 64'({eq32, less32, nl32, dz32}), 64'(4'b0010));
        check("rst_state",   64'(st32),    64'(0));
        check("rst8_res",    64'({res8, res2_8}), 64'(0));
        check("rst8_flags",  64'({st8, busy8, done8, nl8}), 64'(5'b00001));

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, 32'h0,
                  vecs[i].eq, vecs[i].less, 1'b0);
            wait_done(1, 0, $sformatf("vec%0d", i));
        end

        issue(OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        wait_done(34, 10, "mul_ignore");
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        wait_done(34, 0, "div_neg");
        issue(OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 1'b0, 1'b1);
        wait_done(34, 0, "div_zero");
        issue(OP_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_done(1, 0, "dz_clear");
        issue(OP_DIV, 32'hFFFF_FFF7, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0, 1'b0, 1'b1);
        wait_done(34, 0, "div_zero_neg");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_done(34, 0, "div_min");

        for (int i = 0; i < 4; i++) begin
            rx = $urandom;
            if (rx == 32'h8000_0000) rx = 32'h1;
            ry = 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) ry = -ry;
            rop = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV;
            xs = rx;
            ys = ry;
            if (rop == OP_MUL) begin
                p = longint'(xs) * longint'(ys);
                er = p[31:0];
                er2 = p[63:32];
            end else begin
                q = xs / ys;
                r = xs % ys;
                er = q;
                er2 = r;
            end
            issue(rop, rx, ry, er, er2, rx == ry, 1'b0, 1'b0);
            wait_done(34, 0, $sformatf("rand%0d", i));
        end

        // A start presented in the DONE cycle must be dropped, not queued.
        drive_start(OP_ADD, 32'h1, 32'h1);
        @(negedge clk);
        check("dnign_done", 64'(done32), 64'(1));
        drive_pins(1'b1, OP_SUB, 32'h9, 32'h1);
        @(negedge clk);
        drive_pins(1'b0, OP_SUB, 32'h9, 32'h1);
        check("dnign_no_done", 64'(done32), 64'(0));
        check("dnign_idle",    64'(st32),   64'(0));
        @(negedge clk);
        check("dnign_no_queue", 64'(done32), 64'(0));
        check("dnign_res",      64'(res32),  64'(2));

        // Reset during RUN aborts without a done pulse.
        seen_done = 1'b0;
        drive_start(OP_DIV, 32'd100, 32'd3);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done32) seen_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",    64'(busy32), 64'(0));
        check("midrst_res",     64'(res32),  64'(0));
        check("midrst_notless", 64'(nl32),   64'(1));
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32) seen_done = 1'b1;
        end
        check("midrst_no_done", 64'(seen_done), 64'(0));
        issue(OP_ADD, 32'd10, 32'd20, 32'd30, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_done(1, 0, "post_rst_add");

        sel = 1'b1;
        issue(OP_SRA, 32'h80, 32'h0B, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        wait_done(1, 0, "w8_sra");
        issue(OP_MUL, 32'h80, 32'h80, 32'h00, 32'h40, 1'b1, 1'b0, 1'b0);
        wait_done(10, 0, "w8_mul");
        issue(OP_DIV, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0, 1'b0, 1'b0);
        wait_done(10, 0, "w8_div_min");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
